// File: rtl/pair_logic_unit.sv
// pair_logic_unit
// ---------------
// Applies a selectable 2-input logic operation to each adjacent bit pair of
// an IN_W-bit word. In pass mode each accepted word produces one result. In
// accumulate mode ACC_LEN accepted beats are folded into a single result.
// The unit has one output register and full valid/ready backpressure.
//
// Optional feature macro: PLU_PARITY_EN
//   When defined, adds output out_par = ^out_data. It is registered
//   alongside out_data and resets to 0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input word present
//   in_ready   unit accepts the word this cycle
//   in_data    operand word; pair i = {in_data[2i+1], in_data[2i]}
//   mode       00 AND, 01 OR, 10 XOR, 11 NAND
//   acc_en     1 = accumulate, 0 = pass; sampled on each accepted beat
//   out_valid  out_data holds a result
//   out_ready  consumer takes the result
//   out_data   result; bit i belongs to pair i
//   out_par    (PLU_PARITY_EN only) even parity of out_data
//   out_last   result closes a group (always 1 in pass mode)
//   beat_cnt   beats already folded into the current group
module pair_logic_unit #(
  parameter int IN_W    = 4,
  parameter int ACC_LEN = 4,
  localparam int OUT_W  = IN_W / 2,
  localparam int CNT_W  = $clog2(ACC_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       mode,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
`ifdef PLU_PARITY_EN
  output logic             out_par,
`endif
  output logic             out_last,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  // Pairwise operation over the whole input word.
  function automatic logic [OUT_W-1:0] pair_op(input logic [1:0] op,
                                               input logic [IN_W-1:0] word);
    logic [OUT_W-1:0] res;
    res = {OUT_W{1'b0}};
    for (int i = 0; i < OUT_W; i++) begin
      case (op)
        2'b00:   res[i] = word[2*i+1] & word[2*i];
        2'b01:   res[i] = word[2*i+1] | word[2*i];
        2'b10:   res[i] = word[2*i+1] ^ word[2*i];
        2'b11:   res[i] = ~(word[2*i+1] & word[2*i]);
        default: res[i] = 1'b0;
      endcase
    end
    return res;
  endfunction

  // NAND accumulates as AND with a single inversion at group end.
  function automatic logic [1:0] base_op(input logic [1:0] op);
    return (op == 2'b11) ? 2'b00 : op;
  endfunction

  // Combine the running accumulator with a new beat using a base operation.
  function automatic logic [OUT_W-1:0] fold_op(input logic [1:0] op,
                                               input logic [OUT_W-1:0] x,
                                               input logic [OUT_W-1:0] y);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return x & y;
    endcase
  endfunction

  // Even parity of a result word.
  function automatic logic parity(input logic [OUT_W-1:0] x);
    return ^x;
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       mode_q_r, mode_q_s;
  logic [OUT_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_s;
  logic [OUT_W-1:0] data_s;
  logic             last_s;
  logic             accept_s, take_s;
  logic [OUT_W-1:0] pass_res_s, start_res_s, acc_beat_s, fold_s, final_s;

  // In FULL the slot frees only when the consumer takes the result this cycle.
  assign in_ready = (state_r != S_FULL) || out_ready;
  assign accept_s = in_valid && in_ready;
  assign take_s   = out_valid && out_ready;

  // Inside a group every beat uses the base op of the mode latched at group
  // start; the NAND inversion is applied once, to the folded result.
  assign pass_res_s  = pair_op(mode, in_data);
  assign start_res_s = pair_op(base_op(mode), in_data);
  assign acc_beat_s  = pair_op(base_op(mode_q_r), in_data);
  assign fold_s      = fold_op(base_op(mode_q_r), acc_r, acc_beat_s);
  assign final_s     = (mode_q_r == 2'b11) ? ~fold_s : fold_s;

  // Next-state and next-output decode.
  always_comb begin
    state_s  = state_r;
    mode_q_s = mode_q_r;
    acc_s    = acc_r;
    cnt_s    = beat_cnt;
    data_s   = out_data;
    last_s   = out_last;
    case (state_r)
      // FULL with take and accept behaves exactly like a fresh beat in IDLE.
      S_IDLE, S_FULL: begin
        if (accept_s) begin
          if (acc_en) begin
            mode_q_s = mode;
            acc_s    = start_res_s;
            cnt_s    = CNT_W'(1);
            state_s  = S_ACCUM;
          end else begin
            data_s  = pass_res_s;
            last_s  = 1'b1;
            state_s = S_FULL;
          end
        end else if (take_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      // mode and acc_en are ignored here; the group always runs to ACC_LEN.
      S_ACCUM: begin
        if (accept_s) begin
          if (beat_cnt == LAST_CNT) begin
            data_s  = final_s;
            last_s  = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_FULL;
          end else begin
            acc_s   = fold_s;
            cnt_s   = beat_cnt + CNT_W'(1);
            state_s = S_ACCUM;
          end
        end else begin
          state_s = S_ACCUM;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, accumulator and output registers; rst overrides any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      mode_q_r  <= 2'b00;
      acc_r     <= {OUT_W{1'b0}};
      beat_cnt  <= {CNT_W{1'b0}};
      out_data  <= {OUT_W{1'b0}};
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      mode_q_r  <= mode_q_s;
      acc_r     <= acc_s;
      beat_cnt  <= cnt_s;
      out_data  <= data_s;
      out_last  <= last_s;
      out_valid <= (state_s == S_FULL);
    end
  end

`ifdef PLU_PARITY_EN
  // Parity register tracks out_data so both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= 1'b0;
    end else begin
      out_par <= parity(data_s);
    end
  end
`endif

endmodule

// File: tb/tb_pair_logic_unit.sv
// Self-checking bench for pair_logic_unit (IN_W = 4, ACC_LEN = 4).
// Directed scenarios check fixed expected words; a randomized run checks
// every cycle against a pair-counting reference model.
module tb_pair_logic_unit;
  localparam int IN_W    = 4;
  localparam int ACC_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] mode;
  logic       acc_en;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       out_last;
  logic [1:0] beat_cnt;
`ifdef PLU_PARITY_EN
  logic       out_par;
`endif

  int checks = 0;
  int errors = 0;

  pair_logic_unit #(.IN_W(IN_W), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .acc_en(acc_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
`ifdef PLU_PARITY_EN
    .out_par(out_par),
`endif
    .out_last(out_last), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs after the falling edge, then settle.
  task automatic put(input logic r, input logic v, input logic [3:0] d,
                     input logic [1:0] m, input logic a, input logic o);
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; mode = m; acc_en = a; out_ready = o;
    #1;
  endtask

  // ---------------- reference model ----------------
  bit         m_pend;
  logic [1:0] m_data;
  bit         m_grp;
  logic [1:0] m_gmode;
  int         m_n;
  int         m_cnt;
  int         m_ones [2];

  function automatic logic [1:0] ref_pass(input logic [1:0] m, input logic [3:0] d);
    logic [1:0] res;
    logic a, b;
    for (int i = 0; i < 2; i++) begin
      a = d[2*i+1];
      b = d[2*i];
      case (m)
        2'b00:   res[i] = a && b;
        2'b01:   res[i] = a || b;
        2'b10:   res[i] = (a != b);
        default: res[i] = !(a && b);
      endcase
    end
    return res;
  endfunction

  // Group result from the number of 1 bits seen in each pair over all beats.
  function automatic logic [1:0] ref_group();
    logic [1:0] res;
    for (int i = 0; i < 2; i++) begin
      case (m_gmode)
        2'b00:   res[i] = (m_ones[i] == 2 * m_n);
        2'b01:   res[i] = (m_ones[i] > 0);
        2'b10:   res[i] = (m_ones[i] % 2 == 1);
        default: res[i] = (m_ones[i] != 2 * m_n);
      endcase
    end
    return res;
  endfunction

  task automatic model_clear();
    m_pend = 1'b0; m_data = 2'b00; m_grp = 1'b0; m_gmode = 2'b00;
    m_n = 0; m_cnt = 0; m_ones[0] = 0; m_ones[1] = 0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    put(1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
    put(1'b1, 1'b1, 4'b1111, 2'b00, 1'b0, 1'b1);
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL reset_out_data got %b want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (beat_cnt !== 2'd0) begin errors++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef PLU_PARITY_EN
    checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL reset_out_par got %b want 0", out_par); end
`endif
  endtask

  task automatic test_pass_and();
    logic [3:0] din [4];
    logic [1:0] exp [4];
    din = '{4'b0000, 4'b0001, 4'b1010, 4'b1111};
    exp = '{2'b00, 2'b00, 2'b00, 2'b11};
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) put(1'b0, 1'b1, din[k], 2'b00, 1'b0, 1'b1);
      else       put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_in_ready beat %0d got %b want 1", k, in_ready); end
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1 || out_data !== exp[k-1] || out_last !== 1'b1) begin
          errors++; $display("FAIL pass_and beat %0d got v=%b d=%b l=%b want v=1 d=%b l=1", k - 1, out_valid, out_data, out_last, exp[k-1]);
        end
      end
    end
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got %b want 0", out_valid); end
  endtask

  task automatic test_mode_sweep();
    logic [1:0] exp [4];
    exp = '{2'b00, 2'b11, 2'b11, 2'b11};
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) put(1'b0, 1'b1, 4'b1010, 2'(k), 1'b0, 1'b1);
      else       put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1 || out_data !== exp[k-1]) begin
          errors++; $display("FAIL mode_sweep mode %0d got v=%b d=%b want v=1 d=%b", k - 1, out_valid, out_data, exp[k-1]);
        end
      end
    end
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    // OR pass: 0001 -> 01, 0100 -> 10
    put(1'b0, 1'b1, 4'b0001, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      put(1'b0, 1'b1, 4'b0100, 2'b01, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready stall %0d got %b want 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 2'b01) begin
        errors++; $display("FAIL bp_hold stall %0d got v=%b d=%b want v=1 d=01", k, out_valid, out_data);
      end
    end
    put(1'b0, 1'b1, 4'b0100, 2'b01, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1 || out_data !== 2'b01) begin
      errors++; $display("FAIL bp_release got r=%b d=%b want r=1 d=01", in_ready, out_data);
    end
    put(1'b0, 1'b0, 4'b0000, 2'b01, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 2'b10) begin
      errors++; $display("FAIL bp_second got v=%b d=%b want v=1 d=10", out_valid, out_data);
    end
    put(1'b0, 1'b0, 4'b0000, 2'b01, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got v=%b want 0", out_valid); end
  endtask

  task automatic test_accum_and();
    logic [3:0] din [4];
    din = '{4'b1111, 4'b1111, 4'b1011, 4'b1111};
    for (int k = 0; k < 4; k++) begin
      put(1'b0, 1'b1, din[k], 2'b00, 1'b1, 1'b1);
      checks++; if (beat_cnt !== 2'(k)) begin errors++; $display("FAIL acc_beat_cnt before beat %0d got %0d want %0d", k, beat_cnt, k); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_early_valid beat %0d got %b want 0", k, out_valid); end
    end
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 2'b01 || out_last !== 1'b1 || beat_cnt !== 2'd0) begin
      errors++; $display("FAIL acc_and got v=%b d=%b l=%b c=%0d want v=1 d=01 l=1 c=0", out_valid, out_data, out_last, beat_cnt);
    end
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_mode_flip();
    put(1'b0, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b1);
    put(1'b0, 1'b1, 4'b0100, 2'b01, 1'b0, 1'b1);
    put(1'b0, 1'b1, 4'b0000, 2'b01, 1'b1, 1'b1);
    put(1'b0, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b1);
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 2'b00 || out_last !== 1'b1) begin
      errors++; $display("FAIL mode_flip got v=%b d=%b l=%b want v=1 d=00 l=1", out_valid, out_data, out_last);
    end
`ifdef PLU_PARITY_EN
    checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL mode_flip_par got %b want 0", out_par); end
`endif
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_group();
    put(1'b0, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b1);
    put(1'b0, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b1);
    put(1'b1, 1'b1, 4'b0000, 2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      put(1'b0, 1'b1, 4'b1111, 2'b00, 1'b1, 1'b1);
      if (k == 0) begin
        checks++; if (beat_cnt !== 2'd0 || out_valid !== 1'b0) begin
          errors++; $display("FAIL rst_mid_clear got c=%0d v=%b want c=0 v=0", beat_cnt, out_valid);
        end
      end
    end
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 2'b11 || beat_cnt !== 2'd0 || out_last !== 1'b1) begin
      errors++; $display("FAIL rst_mid_group got v=%b d=%b c=%0d l=%b want v=1 d=11 c=0 l=1", out_valid, out_data, beat_cnt, out_last);
    end
`ifdef PLU_PARITY_EN
    checks++; if (out_par !== 1'b0) begin errors++; $display("FAIL rst_mid_par got %b want 0", out_par); end
`endif
    put(1'b0, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic r, v, a, o, exp_ready;
    logic [3:0] d;
    logic [1:0] m;
    put(1'b1, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
    model_clear();
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 75);
      d = 4'($urandom);
      m = 2'($urandom);
      a = ($urandom_range(0, 99) < 60);
      o = ($urandom_range(0, 99) < 70);
      put(r, v, d, m, a, o);
      exp_ready = !m_pend || o;
      checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready cycle %0d got %b want %b", k, in_ready, exp_ready); end
      checks++; if (out_valid !== m_pend) begin errors++; $display("FAIL rnd_out_valid cycle %0d got %b want %b", k, out_valid, m_pend); end
      checks++; if (beat_cnt !== 2'(m_cnt)) begin errors++; $display("FAIL rnd_beat_cnt cycle %0d got %0d want %0d", k, beat_cnt, m_cnt); end
      if (m_pend) begin
        checks++; if (out_data !== m_data || out_last !== 1'b1) begin
          errors++; $display("FAIL rnd_out_data cycle %0d got d=%b l=%b want d=%b l=1", k, out_data, out_last, m_data);
        end
`ifdef PLU_PARITY_EN
        checks++; if (out_par !== (m_data[0] ^ m_data[1])) begin errors++; $display("FAIL rnd_out_par cycle %0d got %b want %b", k, out_par, m_data[0] ^ m_data[1]); end
`endif
      end
      // advance the model across the coming rising edge
      if (r) begin
        model_clear();
      end else begin
        if (m_pend && o) m_pend = 1'b0;
        if (v && exp_ready) begin
          if (m_grp || a) begin
            if (!m_grp) begin
              m_grp = 1'b1; m_gmode = m; m_n = 0; m_ones[0] = 0; m_ones[1] = 0;
            end
            m_n++;
            for (int i = 0; i < 2; i++) m_ones[i] += int'(d[2*i]) + int'(d[2*i+1]);
            if (m_n == ACC_LEN) begin
              m_pend = 1'b1; m_data = ref_group(); m_grp = 1'b0; m_cnt = 0;
            end else begin
              m_cnt = m_n;
            end
          end else begin
            m_pend = 1'b1; m_data = ref_pass(m, d);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'b0000; mode = 2'b00; acc_en = 1'b0; out_ready = 1'b0;
    test_reset();
    test_pass_and();
    test_mode_sweep();
    test_backpressure();
    test_accum_and();
    test_mode_flip();
    test_reset_mid_group();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_logic_unit.md
# pair_logic_unit

Parametrised, registered successor to the 4-in/2-out pairwise AND block. Applies a selectable 2-input logic operation to each adjacent bit pair of an IN_W-bit word. Can optionally fold results across ACC_LEN consecutive beats before emitting one word. Sits between a valid/ready producer and consumer in the PTUvlsi logic-test datapath, with one output register and full backpressure.

## Interface
- IN_W, default 4: input width; must be even and at least 2.
- ACC_LEN, default 4: beats folded per output in accumulate mode; must be at least 2.
- Derived: OUT_W = IN_W/2; CNT_W = clog2(ACC_LEN).
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  unit accepts the word this cycle.
- in_data  in  IN_W  operand word; pair i = {in_data[2i+1], in_data[2i]}.
- mode  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- acc_en  in  1  1 = accumulate mode, 0 = pass mode; sampled with each accepted beat.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer takes the result.
- out_data  out  OUT_W  result; bit i corresponds to pair i.
- out_last  out  1  result closes an accumulation group (always 1 in pass mode).
- beat_cnt  out  CNT_W  beats already folded in the current group.

## Operation
- A beat is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
- Pair result: r[i] = op(in_data[2i+1], in_data[2i]). NAND is ~(a & b).
- FSM states:
  - IDLE: output register empty.
  - ACCUM: partial group held internally; out_valid = 0.
  - FULL: output register holds a result.
- Pass mode (acc_en = 0 at acceptance):
  - r is registered to out_data; out_last = 1.
  - FSM goes to FULL from either IDLE or FULL.
- Accumulate mode, first beat (IDLE/FULL with acc_en = 1):
  - mode is latched into mode_q.
  - acc = r; beat_cnt = 1; FSM goes to ACCUM.
- Accumulate mode, later beats:
  - Beat 2..ACC_LEN-1 folds in using the base op of mode_q: AND for 00 and 11, OR for 01, XOR for 10. beat_cnt increments.
  - Beat ACC_LEN: out_data = fold(acc, r); inverted if mode_q = 11. out_last = 1; beat_cnt returns to 0; FSM goes to FULL.
- While in ACCUM, mode and acc_en on later beats are ignored; the group always completes.
- in_ready:
  - IDLE and ACCUM: 1.
  - FULL: out_ready, giving a 1-deep pipeline with no bubble.
- FULL with take and no accept goes to IDLE. FULL with take and accept behaves as a fresh beat arriving in IDLE.
- Outputs are held stable while out_valid && !out_ready.
- beat_cnt resets to 0 only at group end or on rst.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, beat_cnt 0, state IDLE. in_ready reads 1 the cycle after rst deasserts.
- Pass latency: 1 cycle from acceptance to out_valid. Throughput: 1 word per cycle when out_ready = 1.
- Accumulate latency: out_valid rises 1 cycle after the ACC_LEN-th accepted beat.
- rst asserted mid-group: partial acc is discarded; next accepted beat starts a new group.
- rst while FULL: pending result is dropped; out_valid is 0 the following cycle.
- rst has priority over every simultaneous handshake.

## Configuration
- PLU_PARITY_EN defined:
  - Adds output port out_par (1 bit) = ^out_data.
  - out_par is registered with out_data and resets to 0.
- PLU_PARITY_EN undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use IN_W = 4 and ACC_LEN = 4.
- Pass, AND, out_ready = 1: in_data 0000, 0001, 1010, 1111 on consecutive cycles -> out_data 00, 00, 00, 11 one cycle later each; out_last = 1 throughout.
- Pass, mode sweep with in_data = 1010: AND, OR, XOR, NAND -> out_data 00, 11, 11, 11.
- Backpressure: out_ready = 0 for 3 cycles with in_valid held -> in_ready = 0 after the first result; out_data stable; no beat lost or duplicated after release.
- Accumulate AND: beats 1111, 1111, 1011, 1111 -> single out_data = 01 with out_last = 1; beat_cnt steps 1, 2, 3, 0.
- Accumulate, mode flip: group starts XOR and mode switches to OR mid-group; beats 0100, 0100, 0000, 0000 -> out_data = 00 (XOR kept). Verify PLU_PARITY_EN on/off: out_par = 0.
- Reset mid-group: rst after 2 beats, then 4 AND beats of 1111 -> out_data = 11, beat_cnt = 0 after completion.
